// File: rtl/fp_mult_sequencer_if.sv
// fp_mult_sequencer_if: operand/result handshake between the ALU operand registers and the FP multiplier
interface fp_mult_sequencer_if;
  logic start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic busy;
  logic done;
  logic [31:0] dataR;
  modport master(output start, dataA, dataB, input busy, done, dataR);
  modport slave(input start, dataA, dataB, output busy, done, dataR);
endinterface

// File: rtl/fp_mult_sequencer.sv
// fp_mult_sequencer: iterative IEEE-754 single multiplier, shift-add of BITS_PER_CYCLE bits per clock, truncating
module fp_mult_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic reset,
  fp_mult_sequencer_if.slave bus
);
  localparam int N = 24 / BITS_PER_CYCLE;
  typedef enum logic [2:0] {IDLE, CHECK, MULT, NORM, DONE} state_t;
  state_t state;
  logic [31:0] a, b, spec_r, norm_r;
  logic [47:0] p, pp;
  logic [4:0] cnt;
  logic [5:0] sh;
  logic [BITS_PER_CYCLE-1:0] bits;
  logic sr, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, special, unused;
  logic signed [9:0] x;
  logic [22:0] frac;
  always_comb begin
    sh = 6'(cnt * BITS_PER_CYCLE);
    bits = BITS_PER_CYCLE'({1'b1, b[22:0]} >> sh);
    pp = ({24'b0, 1'b1, a[22:0]} * 48'(bits)) << sh;
    sr = a[31] ^ b[31];
    nan_a = a[30:23] == 8'hFF && a[22:0] != 23'h0;
    nan_b = b[30:23] == 8'hFF && b[22:0] != 23'h0;
    inf_a = a[30:23] == 8'hFF && a[22:0] == 23'h0;
    inf_b = b[30:23] == 8'hFF && b[22:0] == 23'h0;
    zero_a = a[30:23] == 8'h0;
    zero_b = b[30:23] == 8'h0;
    special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
    spec_r = (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) ? 32'h7FC00000 :
             (inf_a | inf_b) ? {sr, 8'hFF, 23'h0} : {sr, 31'h0};
    x = 10'(a[30:23]) + 10'(b[30:23]) - 10'sd127 + 10'(p[47]);
    frac = p[47] ? p[46:24] : p[45:23];
    norm_r = (x >= 10'sd255) ? {sr, 8'hFF, 23'h0} : (x <= 10'sd0) ? {sr, 31'h0} : {sr, x[7:0], frac};
    unused = ^p[22:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      p <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.dataR <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a <= bus.dataA;
          b <= bus.dataB;
          bus.busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (special) begin
          bus.dataR <= spec_r;
          bus.done <= 1'b1;
          state <= DONE;
        end else begin
          p <= '0;
          cnt <= '0;
          state <= MULT;
        end
        MULT: begin
          p <= p + pp;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(N - 1)) state <= NORM;
        end
        NORM: begin
          bus.dataR <= norm_r;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult_sequencer.sv
// tb_fp_mult_sequencer: runs BITS_PER_CYCLE=1 and =4 instances side by side against an arithmetic reference model
module tb_fp_mult_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] da = 0, db = 0;
  int checks = 0, failures = 0;
  logic done_v[2], busy_v[2];
  logic [31:0] r_v[2];
  int nn[2] = '{24, 6};
  int bpc[2] = '{1, 4};
  always #5 clk = ~clk;
  fp_mult_sequencer_if bus1();
  fp_mult_sequencer_if bus4();
  assign bus1.start = start;
  assign bus1.dataA = da;
  assign bus1.dataB = db;
  assign bus4.start = start;
  assign bus4.dataA = da;
  assign bus4.dataB = db;
  assign done_v[0] = bus1.done;
  assign busy_v[0] = bus1.busy;
  assign r_v[0] = bus1.dataR;
  assign done_v[1] = bus4.done;
  assign busy_v[1] = bus4.busy;
  assign r_v[1] = bus4.dataR;
  fp_mult_sequencer #(.BITS_PER_CYCLE(1)) dut1(.clk(clk), .reset(reset), .bus(bus1));
  fp_mult_sequencer #(.BITS_PER_CYCLE(4)) dut4(.clk(clk), .reset(reset), .bus(bus4));

  function automatic bit is_special(logic [31:0] a, logic [31:0] b);
    return a[30:23] == 0 || a[30:23] == 255 || b[30:23] == 0 || b[30:23] == 255;
  endfunction

  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    logic sr = a[31] ^ b[31];
    bit na = ea == 255 && a[22:0] != 0;
    bit nb = eb == 255 && b[22:0] != 0;
    bit ia = ea == 255 && a[22:0] == 0;
    bit ib = eb == 255 && b[22:0] == 0;
    bit za = ea == 0;
    bit zb = eb == 0;
    logic [47:0] prod;
    logic [22:0] f;
    int x;
    if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {sr, 8'hFF, 23'h0};
    if (za || zb) return {sr, 31'h0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    x = ea + eb - 127;
    if (prod[47]) begin
      x++;
      f = 23'(prod >> 24);
    end else f = 23'(prod >> 23);
    if (x >= 255) return {sr, 8'hFF, 23'h0};
    if (x <= 0) return {sr, 31'h0};
    return {sr, 8'(x), f};
  endfunction

  // hold=1 re-asserts start with other operands in cycles 5-10; only the BITS_PER_CYCLE=4 unit is idle by cycle 10
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input string name);
    logic [31:0] ha = 32'h40A00000, hb = 32'h3E800000;
    logic [31:0] expv = ref_mul(a, b);
    logic [31:0] prev[2], got[2], fin[2];
    int first[2], cnt[2], ecnt[2], lat;
    bit busy_bad[2], hold_bad[2];
    for (int d = 0; d < 2; d++) begin
      prev[d] = r_v[d];
      first[d] = -1;
      cnt[d] = 0;
      busy_bad[d] = 0;
      hold_bad[d] = 0;
      got[d] = 'x;
      ecnt[d] = (hold && d == 1) ? 2 : 1;
      fin[d] = (hold && d == 1) ? ref_mul(ha, hb) : expv;
    end
    @(negedge clk);
    start = 1;
    da = a;
    db = b;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 0;
      if (hold && i == 5) begin
        start = 1;
        da = ha;
        db = hb;
      end
      if (hold && i == 11) start = 0;
      for (int d = 0; d < 2; d++) begin
        if (done_v[d] === 1'b1) begin
          cnt[d]++;
          if (first[d] < 0) begin
            first[d] = i;
            got[d] = r_v[d];
          end
        end
        if (first[d] < 0 && r_v[d] !== prev[d]) hold_bad[d] = 1;
        if ((first[d] < 0 || first[d] == i) && busy_v[d] !== 1'b1) busy_bad[d] = 1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      lat = is_special(a, b) ? 2 : nn[d] + 3;
      checks++;
      if (first[d] != lat) begin
        failures++;
        $display("FAIL %s bpc=%0d latency got=%0d exp=%0d", name, bpc[d], first[d], lat);
      end
      checks++;
      if (cnt[d] != ecnt[d]) begin
        failures++;
        $display("FAIL %s bpc=%0d done_count got=%0d exp=%0d", name, bpc[d], cnt[d], ecnt[d]);
      end
      checks++;
      if (got[d] !== expv) begin
        failures++;
        $display("FAIL %s bpc=%0d dataR A=%h B=%h got=%h exp=%h", name, bpc[d], a, b, got[d], expv);
      end
      checks++;
      if (busy_bad[d]) begin
        failures++;
        $display("FAIL %s bpc=%0d busy got=0 exp=1 during op", name, bpc[d]);
      end
      checks++;
      if (hold_bad[d] || r_v[d] !== fin[d]) begin
        failures++;
        $display("FAIL %s bpc=%0d dataR_hold got=%h exp=%h early_change=%0d", name, bpc[d], r_v[d], fin[d], hold_bad[d]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 0 || done_v[d] !== 0 || r_v[d] !== 0) begin
        failures++;
        $display("FAIL reset bpc=%0d busy/done/dataR got=%b/%b/%h exp=0/0/0", bpc[d], busy_v[d], done_v[d], r_v[d]);
      end
    end
    reset = 0;
  endtask

  task automatic test_basic();
    run_op(32'h3FC00000, 32'h40000000, 0, "mul_1p5x2");
    run_op(32'h3FC00000, 32'h3FC00000, 0, "mul_p47");
    run_op(32'hC0400000, 32'h3F000000, 0, "mul_neg");
  endtask

  task automatic test_special();
    run_op(32'h7F800000, 32'h00000000, 0, "inf_x_zero");
    run_op(32'hFF800000, 32'h40000000, 0, "neg_inf");
    run_op(32'h7FC00001, 32'h3F800000, 0, "nan");
    run_op(32'h3F800000, 32'h807FFFFF, 0, "denorm_flush");
  endtask

  task automatic test_range();
    run_op(32'h7F000000, 32'h7F000000, 0, "overflow");
    run_op(32'h00800000, 32'h00800000, 0, "underflow");
    run_op(32'h80800000, 32'h00800000, 0, "underflow_neg");
  endtask

  task automatic test_handshake();
    run_op(32'h40400000, 32'h40400000, 1, "handshake");
  endtask

  task automatic test_midop_reset();
    bit early = 0, late = 0;
    @(negedge clk);
    start = 1;
    da = 32'h3FC00000;
    db = 32'h40000000;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 0;
      if (done_v[0] === 1'b1) early = 1;
      if (i == 10) reset = 1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 0 || done_v[d] !== 0 || r_v[d] !== 0) begin
        failures++;
        $display("FAIL midop_reset bpc=%0d busy/done/dataR got=%b/%b/%h exp=0/0/0", bpc[d], busy_v[d], done_v[d], r_v[d]);
      end
    end
    reset = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || done_v[1] === 1'b1) late = 1;
    end
    checks++;
    if (early || late) begin
      failures++;
      $display("FAIL midop_reset spurious_done got=%0d/%0d exp=0/0", early, late);
    end
    run_op(32'hC0A00000, 32'h3F400000, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int d1[2], d2[2];
    bit idle = 0;
    d1 = '{-1, -1};
    d2 = '{-1, -1};
    @(negedge clk);
    start = 1;
    da = 32'h40490FDB;
    db = 32'h402DF854;
    @(posedge clk);
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        if (done_v[d] === 1'b1) begin
          if (d1[d] < 0) d1[d] = i;
          else if (d2[d] < 0) d2[d] = i;
        end
    end
    start = 0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (d1[d] != nn[d] + 3 || d2[d] - d1[d] != nn[d] + 4) begin
        failures++;
        $display("FAIL back_to_back bpc=%0d done_cycles got=%0d,%0d exp=%0d,%0d", bpc[d], d1[d], d2[d], nn[d] + 3, 2 * nn[d] + 7);
      end
      checks++;
      if (r_v[d] !== ref_mul(32'h40490FDB, 32'h402DF854)) begin
        failures++;
        $display("FAIL back_to_back bpc=%0d dataR got=%h exp=%h", bpc[d], r_v[d], ref_mul(32'h40490FDB, 32'h402DF854));
      end
    end
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = busy_v[0] === 1'b0 && busy_v[1] === 1'b0;
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("FAIL back_to_back drain got=busy exp=idle within 60 cycles");
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int k = 0; k < 16; k++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[30:23] = 8'($urandom_range(64, 190));
        b[30:23] = 8'($urandom_range(64, 190));
      end
      run_op(a, b, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_range();
    test_handshake();
    test_midop_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
